// File: rtl/riscv_zero_pkg.sv
// Shared constants and the writeback entry type for the riscv_zero writeback path.
package riscv_zero_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/riscv_zero_wb_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module riscv_zero_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and occupancy; flush drops everything at the edge.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/riscv_zero_wb_arbiter.sv
// Shares the register-file write port between the buffered ALU path and the
// unbuffered load path. Loads win by default; an ALU head that has lost
// MAX_WAIT times in a row is forced through. Write port is registered.
module riscv_zero_wb_arbiter
  import riscv_zero_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3,
  parameter int XLEN     = riscv_zero_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  reg_wenable,
  output logic [REG_ADDR_W-1:0] reg_waddr,
  output logic [XLEN-1:0]       reg_wdata,
  output logic                  collision_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int EW = REG_ADDR_W + XLEN;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EW-1:0]         fifo_rdata;
  logic                  unused_fifo_full;
  logic                  head_valid, force_alu, ld_grant, alu_grant, collision;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  err_q, err_d;

  assign unused_fifo_full = fifo_full;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign alu_ready = (fifo_count < CW'(DEPTH)) && !flush;
  assign fifo_push = alu_valid && alu_ready && (alu_rd != '0);

  assign head_valid = !fifo_empty;
  assign head_rd    = fifo_rdata[XLEN +: REG_ADDR_W];
  assign head_data  = fifo_rdata[XLEN-1:0];

  assign force_alu = head_valid && (starve_q == STARVE_MAX);
  assign ld_grant  = ld_valid && !force_alu;
  assign ld_ready  = ld_grant;
  assign alu_grant = head_valid && !ld_grant;
  assign fifo_pop  = alu_grant;
  assign collision = head_valid && ld_valid && (head_rd == ld_rd) && (ld_rd != '0);

  riscv_zero_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({alu_rd, alu_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next starvation count, write-port contents and sticky collision flag.
  always_comb begin
    starve_d = starve_q;
    if (flush || !head_valid || alu_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (ld_grant) begin
      if (ld_rd != '0) begin
        wen_d   = 1'b1;
        waddr_d = ld_rd;
        wdata_d = ld_data;
      end
    end else if (alu_grant) begin
      wen_d   = 1'b1;
      waddr_d = head_rd;
      wdata_d = head_data;
    end

    err_d = err_q | collision;
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign reg_wenable   = wen_q;
  assign reg_waddr     = waddr_q;
  assign reg_wdata     = wdata_q;
  assign collision_err = err_q;

endmodule

// File: tb/tb_riscv_zero_wb_arbiter.sv
// Bench for riscv_zero_wb_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_riscv_zero_wb_arbiter;
  import riscv_zero_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1, flush = 1'b0;
  logic            alu_valid = 1'b0, ld_valid = 1'b0;
  logic            alu_ready, ld_ready;
  logic [4:0]      alu_rd = '0, ld_rd = '0, reg_waddr;
  logic [XLEN-1:0] alu_data = '0, ld_data = '0, reg_wdata;
  logic            reg_wenable, collision_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  riscv_zero_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .reg_wenable(reg_wenable), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .collision_err(collision_err)
  );

  // Reference model: pending ALU results as a queue, plus the visible write port.
  wb_entry_t       mq[$];
  int              m_starve = 0;
  logic            m_we = 1'b0, m_err = 1'b0;
  logic [4:0]      m_waddr = '0;
  logic [XLEN-1:0] m_wdata = '0;
  logic            e_alu_ready, e_ld_ready;

  function automatic void model_comb();
    e_alu_ready = (mq.size() < DEPTH) && !flush;
    e_ld_ready  = ld_valid && !((mq.size() > 0) && (m_starve == MAX_WAIT));
  endfunction

  task automatic tick();
    bit hv;
    model_comb();
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      m_starve = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    end else begin
      hv = (mq.size() > 0);
      if (hv && ld_valid && ld_rd != 0 && mq[0].rd == ld_rd) m_err = 1'b1;
      m_we = 1'b0;
      if (e_ld_ready) begin
        if (ld_rd != 0) begin m_we = 1'b1; m_waddr = ld_rd; m_wdata = ld_data; end
      end else if (hv) begin
        m_we = 1'b1; m_waddr = mq[0].rd; m_wdata = mq[0].data;
      end
      if (flush || !hv || !e_ld_ready) m_starve = 0;
      else if (m_starve < MAX_WAIT) m_starve++;
      if (hv && !e_ld_ready) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (alu_valid && e_alu_ready && alu_rd != 0) mq.push_back({alu_rd, alu_data});
    end
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", reg_wenable); end
    total++; if (reg_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", reg_waddr); end
    total++; if (reg_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", reg_wdata); end
    total++; if (collision_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", collision_err); end
    reset = 1'b0;
    #3;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready got=%b exp=1", alu_ready); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    // reset while an ALU result is queued and a write is on the port
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
    tick();
    idle(); ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 64'h8888;
    tick();
    total++; if (reg_wenable !== 1'b1 || reg_waddr !== 5'd8) begin bad++; $display("FAIL midreset_pre got=%b/%0d exp=1/8", reg_wenable, reg_waddr); end
    idle(); reset = 1'b1;
    tick();
    total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL midreset_wen got=%b exp=0", reg_wenable); end
    reset = 1'b0;
    tick();
    total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL midreset_discard got=%b exp=0", reg_wenable); end
  endtask

  task automatic test_alu_only();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      alu_valid = (k < 3);
      alu_rd    = 5'(k + 1);
      alu_data  = 64'(8'h11 * (k + 1));
      #3;
      total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL alu_only_ready k=%0d got=%b exp=1", k, alu_ready); end
      tick();
      if (k >= 1 && k <= 3) begin
        total++;
        if (reg_wenable !== 1'b1 || reg_waddr !== 5'(k) || reg_wdata !== 64'(8'h11 * k)) begin
          bad++; $display("FAIL alu_only_write k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, reg_wenable, reg_waddr, reg_wdata, k, 8'h11 * k);
        end
      end else begin
        total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL alu_only_idle k=%0d got=%b exp=0", k, reg_wenable); end
      end
    end
    // hold the port with loads so two ALU results pile up
    apply_reset();
    ld_valid = 1'b1; ld_rd = 5'd20; alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hA;
    tick();
    alu_rd = 5'd11; alu_data = 64'hB;
    tick();
    alu_valid = 1'b0;
    #3;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL alu_full_ready got=%b exp=0", alu_ready); end
    idle();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h5555;
    ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 64'h6666;
    #3;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL same_ld_ready got=%b exp=1", ld_ready); end
    tick();
    idle();
    total++; if (reg_wenable !== 1'b1 || reg_waddr !== 5'd6 || reg_wdata !== 64'h6666) begin
      bad++; $display("FAIL same_first got=%b/%0d/%h exp=1/6/6666", reg_wenable, reg_waddr, reg_wdata); end
    tick();
    total++; if (reg_wenable !== 1'b1 || reg_waddr !== 5'd5 || reg_wdata !== 64'h5555) begin
      bad++; $display("FAIL same_second got=%b/%0d/%h exp=1/5/5555", reg_wenable, reg_waddr, reg_wdata); end
    tick();
    total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL same_after got=%b exp=0", reg_wenable); end
  endtask

  task automatic test_starvation();
    logic [4:0]      rd_s;
    logic [XLEN-1:0] d_s;
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7777;
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      rd_s = 5'($urandom_range(8, 31)); d_s = {$urandom(), $urandom()};
      ld_rd = rd_s; ld_data = d_s;
      #3;
      total++; if (ld_ready !== (i != 3)) begin bad++; $display("FAIL starve_ld_ready i=%0d got=%b exp=%b", i, ld_ready, i != 3); end
      tick();
      if (i == 3) begin
        total++; if (reg_wenable !== 1'b1 || reg_waddr !== 5'd7 || reg_wdata !== 64'h7777) begin
          bad++; $display("FAIL starve_forced got=%b/%0d/%h exp=1/7/7777", reg_wenable, reg_waddr, reg_wdata); end
      end else begin
        total++; if (reg_wenable !== 1'b1 || reg_waddr !== rd_s || reg_wdata !== d_s) begin
          bad++; $display("FAIL starve_load i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, reg_wenable, reg_waddr, reg_wdata, rd_s, d_s); end
      end
    end
    idle();
  endtask

  task automatic test_x0();
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 64'hBEEF;
    #3;
    total++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin bad++; $display("FAIL x0_handshake got=%b/%b exp=1/1", alu_ready, ld_ready); end
    tick();
    idle();
    total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", reg_wenable); end
    #3;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL x0_count got=%b exp=1", alu_ready); end
    tick();
    total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL x0_nodrain got=%b exp=0", reg_wenable); end
  endtask

  task automatic test_flush();
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC;
    ld_valid  = 1'b1; ld_rd  = 5'd20; ld_data  = 64'h14;
    tick();
    alu_rd = 5'd13; alu_data = 64'hD; ld_rd = 5'd21; ld_data = 64'h15;
    tick();
    total++; if (reg_waddr !== 5'd21) begin bad++; $display("FAIL flush_pre got=%0d exp=21", reg_waddr); end
    flush = 1'b1; alu_rd = 5'd14; ld_rd = 5'd9; ld_data = 64'h99;
    #3;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL flush_alu_ready got=%b exp=0", alu_ready); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL flush_ld_ready got=%b exp=1", ld_ready); end
    tick();
    idle();
    total++; if (reg_wenable !== 1'b1 || reg_waddr !== 5'd9 || reg_wdata !== 64'h99) begin
      bad++; $display("FAIL flush_load got=%b/%0d/%h exp=1/9/99", reg_wenable, reg_waddr, reg_wdata); end
    for (int k = 0; k < 4; k++) begin
      #3;
      total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL flush_empty k=%0d got=%b exp=1", k, alu_ready); end
      tick();
      total++; if (reg_wenable !== 1'b0) begin bad++; $display("FAIL flush_nowrite k=%0d got=%b exp=0", k, reg_wenable); end
    end
  endtask

  task automatic test_collision();
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hAAAA;
    tick();
    idle();
    total++; if (collision_err !== 1'b0) begin bad++; $display("FAIL coll_early got=%b exp=0", collision_err); end
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'hBBBB;
    #3;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL coll_ld_ready got=%b exp=1", ld_ready); end
    tick();
    idle();
    total++; if (collision_err !== 1'b1) begin bad++; $display("FAIL coll_set got=%b exp=1", collision_err); end
    total++; if (reg_waddr !== 5'd4 || reg_wdata !== 64'hBBBB) begin bad++; $display("FAIL coll_load got=%0d/%h exp=4/bbbb", reg_waddr, reg_wdata); end
    tick();
    total++; if (reg_wenable !== 1'b1 || reg_wdata !== 64'hAAAA) begin bad++; $display("FAIL coll_alu got=%b/%h exp=1/aaaa", reg_wenable, reg_wdata); end
    for (int k = 0; k < 5; k++) tick();
    total++; if (collision_err !== 1'b1) begin bad++; $display("FAIL coll_sticky got=%b exp=1", collision_err); end
    apply_reset();
    total++; if (collision_err !== 1'b0) begin bad++; $display("FAIL coll_clear got=%b exp=0", collision_err); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = {$urandom(), $urandom()};
      ld_valid  = ($urandom_range(0, 2) != 0);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = {$urandom(), $urandom()};
      #3;
      model_comb();
      total++; if (alu_ready !== e_alu_ready) begin bad++; $display("FAIL rnd_alu_ready cyc=%0d got=%b exp=%b", cyc, alu_ready, e_alu_ready); end
      total++; if (ld_ready !== e_ld_ready) begin bad++; $display("FAIL rnd_ld_ready cyc=%0d got=%b exp=%b", cyc, ld_ready, e_ld_ready); end
      tick();
      total++; if (reg_wenable !== m_we) begin bad++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", cyc, reg_wenable, m_we); end
      total++; if (reg_waddr !== m_waddr) begin bad++; $display("FAIL rnd_waddr cyc=%0d got=%0d exp=%0d", cyc, reg_waddr, m_waddr); end
      total++; if (reg_wdata !== m_wdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, reg_wdata, m_wdata); end
      total++; if (collision_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, collision_err, m_err); end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_same_cycle();
    test_starvation();
    test_x0();
    test_flush();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
